// File: rtl/regfile_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_if
//
// Purpose:
//    Bundles the signals between the two writeback sources, the issue-stage
//    hazard check and the register-file write arbiter.
//
// Signals:
//    a_valid/a_ready/a_reg/a_data  ALU writeback request (high priority)
//    b_valid/b_ready/b_reg/b_data  multi-cycle unit writeback (low priority)
//    rf_we/rf_wreg/rf_wdata        registered register-file write port
//    chk_reg1/chk_reg2             operand register numbers to check
//    chk_pend1/chk_pend2           pending-write flags for those operands
//    b_forced                      current B grant is a starvation override
//    fwd1_hit/fwd1_data/fwd2_hit/fwd2_data
//                                  bypass outputs, present only when
//                                  REGWB_FWD_EN is defined
//
// Modports:
//    master  drives requests and operand checks (sources + issue stage)
//    slave   the arbiter itself
// -----------------------------------------------------------------------------
interface regfile_write_arbiter_if;

   logic        a_valid;
   logic        a_ready;
   logic [4:0]  a_reg;
   logic [31:0] a_data;

   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_reg;
   logic [31:0] b_data;

   logic        rf_we;
   logic [4:0]  rf_wreg;
   logic [31:0] rf_wdata;

   logic [4:0]  chk_reg1;
   logic [4:0]  chk_reg2;
   logic        chk_pend1;
   logic        chk_pend2;

   logic        b_forced;

`ifdef REGWB_FWD_EN
   logic        fwd1_hit;
   logic [31:0] fwd1_data;
   logic        fwd2_hit;
   logic [31:0] fwd2_data;
`endif

   modport master (
      output a_valid, a_reg, a_data,
      output b_valid, b_reg, b_data,
      output chk_reg1, chk_reg2,
      input  a_ready, b_ready,
      input  rf_we, rf_wreg, rf_wdata,
      input  chk_pend1, chk_pend2,
      input  b_forced
`ifdef REGWB_FWD_EN
      , input fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
`endif
   );

   modport slave (
      input  a_valid, a_reg, a_data,
      input  b_valid, b_reg, b_data,
      input  chk_reg1, chk_reg2,
      output a_ready, b_ready,
      output rf_we, rf_wreg, rf_wdata,
      output chk_pend1, chk_pend2,
      output b_forced
`ifdef REGWB_FWD_EN
      , output fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
`endif
   );

endinterface

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Purpose:
//    Shares the single register-file write port between the ALU writeback
//    (source A, high priority) and the multi-cycle unit writeback (source B,
//    low priority). B is guaranteed progress: once it has been refused
//    MAX_WAIT cycles in a row while valid, it wins the next arbitration.
//    The winning request is registered and drives the register file one
//    cycle later. A combinational lookup reports whether a write to either
//    issue-stage operand is still outstanding.
//
// Ports:
//    clk   system clock, all state updates on the rising edge
//    rst   synchronous reset, active-high
//    bus   regfile_write_arbiter_if.slave (requests, write port, lookups)
//
// Parameters:
//    MAX_WAIT  refusals of a valid B before it is forced to win (1..15)
//    CNT_W     starvation counter width, must hold MAX_WAIT
//
// Build option:
//    REGWB_FWD_EN  adds fwd1/fwd2 bypass outputs driven from the output
//                  register, so the issue stage can forward instead of
//                  stalling on the write-before-read gap.
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned CNT_W    = 4
) (
   input logic                    clk,
   input logic                    rst,
   regfile_write_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_A    = 2'd1,
      GNT_B    = 2'd2
   } grant_e;

   grant_e           grant;
   logic             starved;
   logic             forced;
   logic [CNT_W-1:0] wait_cnt;

   logic [4:0]       sel_reg;
   logic [31:0]      sel_data;

   logic             rf_we_q;
   logic [4:0]       rf_wreg_q;
   logic [31:0]      rf_wdata_q;

   // --------------------------------------------------------------------------
   // Arbitration
   // --------------------------------------------------------------------------
   // NOTE: every signal written in this block gets a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      grant   = GNT_NONE;
      forced  = 1'b0;
      starved = (wait_cnt >= MAX_WAIT_C);

      // Grants are suppressed during reset so nothing is consumed that the
      // output stage would then throw away.
      if (!rst) begin
         if (bus.a_valid && bus.b_valid) begin
            if (starved) begin
               grant  = GNT_B;
               forced = 1'b1;
            end else begin
               grant  = GNT_A;
            end
         end else if (bus.a_valid) begin
            grant = GNT_A;
         end else if (bus.b_valid) begin
            grant = GNT_B;
         end
      end
   end

   assign bus.a_ready  = (grant == GNT_A);
   assign bus.b_ready  = (grant == GNT_B);
   assign bus.b_forced = forced;

   always_comb begin
      sel_reg  = bus.a_reg;
      sel_data = bus.a_data;
      if (grant == GNT_B) begin
         sel_reg  = bus.b_reg;
         sel_data = bus.b_data;
      end
   end

   // --------------------------------------------------------------------------
   // Starvation counter
   // --------------------------------------------------------------------------
   // Counts consecutive cycles B is valid but refused. Any cycle B drops its
   // request, or wins, starts the count again from zero.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (!bus.b_valid || grant == GNT_B) begin
         wait_cnt <= '0;
      end else if (!starved) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // --------------------------------------------------------------------------
   // Output stage
   // --------------------------------------------------------------------------
   // A grant to register 0 is consumed but produces no write; the address and
   // data registers keep their previous contents in that case as well, so the
   // write port only ever shows real writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we_q    <= 1'b0;
         rf_wreg_q  <= '0;
         rf_wdata_q <= '0;
      end else if (grant != GNT_NONE && sel_reg != 5'd0) begin
         rf_we_q    <= 1'b1;
         rf_wreg_q  <= sel_reg;
         rf_wdata_q <= sel_data;
      end else begin
         rf_we_q    <= 1'b0;
      end
   end

   assign bus.rf_we    = rf_we_q;
   assign bus.rf_wreg  = rf_wreg_q;
   assign bus.rf_wdata = rf_wdata_q;

   // --------------------------------------------------------------------------
   // Pending-write lookup
   // --------------------------------------------------------------------------
   // A write is outstanding while it is requested by either source or sitting
   // in the output register (the register file commits it at the end of that
   // cycle). Register 0 is never written, so it is never pending.
   function automatic logic pending(
      input logic [4:0] chk,
      input logic       a_v,
      input logic [4:0] a_r,
      input logic       b_v,
      input logic [4:0] b_r,
      input logic       we,
      input logic [4:0] wr
   );
      return (chk != 5'd0) &&
             ((a_v && a_r == chk) || (b_v && b_r == chk) || (we && wr == chk));
   endfunction

   assign bus.chk_pend1 = pending(bus.chk_reg1, bus.a_valid, bus.a_reg,
                                  bus.b_valid, bus.b_reg, rf_we_q, rf_wreg_q);
   assign bus.chk_pend2 = pending(bus.chk_reg2, bus.a_valid, bus.a_reg,
                                  bus.b_valid, bus.b_reg, rf_we_q, rf_wreg_q);

   // --------------------------------------------------------------------------
   // Optional bypass from the output register
   // --------------------------------------------------------------------------
`ifdef REGWB_FWD_EN
   assign bus.fwd1_hit  = rf_we_q && (rf_wreg_q == bus.chk_reg1) &&
                          (bus.chk_reg1 != 5'd0);
   assign bus.fwd1_data = rf_wdata_q;
   assign bus.fwd2_hit  = rf_we_q && (rf_wreg_q == bus.chk_reg2) &&
                          (bus.chk_reg2 != 5'd0);
   assign bus.fwd2_data = rf_wdata_q;
`else
   // Without the bypass the issue stage relies on chk_pend1/chk_pend2 alone.
`endif

endmodule
